// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared geometry, FSM encoding and address helpers for the
//               direct-mapped instruction cache. Cache geometry is set here
//               (LINE_WORDS, SETS, MEM_AW) and every derived width follows.
// Revision    : 1.0  initial release
// ============================================================================
package icache_pkg;

  localparam int LINE_WORDS = 4;   // words per line, power of two, >= 2
  localparam int SETS       = 16;  // number of lines, power of two
  localparam int MEM_AW     = 12;  // instruction RAM word-address width

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = MEM_AW - OFF_W - IDX_W;

  // Controller states
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REFILL = 2'd1;
  localparam logic [1:0] LAST   = 2'd2;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [OFF_W-1:0] off_t;

  typedef struct packed {
    tag_t tag;
    idx_t idx;
    off_t off;
  } addr_fields_t;

  // Byte address -> {tag, index, offset}; byte-lane bits and bits above the
  // RAM word range are dropped.
  function automatic addr_fields_t addr_split(input logic [31:0] byte_addr);
    addr_fields_t f;
    f = byte_addr[MEM_AW+1:2];
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_line_store.sv
`default_nettype none
// ============================================================================
// Module      : icache_line_store
// Description : Register-based valid/tag/data storage for the cache. Reads are
//               combinational by index/offset; refill writes one word at a
//               time; a line becomes visible only when committed. Only the
//               valid bits are reset - tag and data contents are don't-care
//               while their line is invalid.
// Revision    : 1.0  initial release
// ============================================================================
module icache_line_store
  import icache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  idx_t        rd_idx,
  input  off_t        rd_off,
  output logic        rd_valid,
  output tag_t        rd_tag,
  output logic [31:0] rd_data,
  input  logic        wr_en,
  input  idx_t        wr_idx,
  input  off_t        wr_off,
  input  logic [31:0] wr_data,
  input  logic        commit,
  input  tag_t        commit_tag,
  input  logic        inval_all
);

  logic [SETS-1:0] valid;
  tag_t            tag_mem  [SETS];
  logic [31:0]     data_mem [SETS*LINE_WORDS];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[{rd_idx, rd_off}];

  // Valid bits: flash-invalidate beats a commit in the same cycle so a flush
  // that overlaps a refill leaves the new line invalid too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (inval_all) begin
      valid <= '0;
    end else if (commit) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays are plain storage without reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      tag_mem[wr_idx] <= commit_tag;
    end
    if (wr_en) begin
      data_mem[{wr_idx, wr_off}] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/icache_direct_mapped.sv
`default_nettype none
// ============================================================================
// Module      : icache_direct_mapped
// Description : Direct-mapped read-only instruction cache. Hits are answered
//               in the request cycle; a miss stalls fetch while one full line
//               is streamed from a 1-cycle-latency word RAM. Hit and refill
//               counters are provided for performance measurement.
// Revision    : 1.0  initial release
// ============================================================================
module icache_direct_mapped
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [31:0]       cpu_addr,
  input  logic              cpu_flush,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_valid,
  output logic              cpu_stall,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  logic [1:0]   state;
  tag_t         base_tag;
  idx_t         base_idx;
  off_t         issue_cnt;
  logic         flush_pend;

  addr_fields_t req;
  logic         line_valid;
  tag_t         line_tag;
  logic [31:0]  line_data;
  logic         hit;
  logic         miss_start;
  logic         last_word;
  logic         refill_we;
  logic         inval_all;
  logic         commit;

  assign req = addr_split(cpu_addr);

  assign hit        = (state == IDLE) & cpu_req & line_valid & (line_tag == req.tag);
  assign miss_start = (state == IDLE) & cpu_req & ~hit;
  assign last_word  = (issue_cnt == off_t'(LINE_WORDS - 1));

  // Word k arrives one cycle after its address, so the write lags issue by
  // one; in LAST issue_cnt has wrapped to 0 and issue_cnt-1 is the top word.
  assign refill_we = ((state == REFILL) & (issue_cnt != '0)) | (state == LAST);

  // A flush seen in LAST is folded into the same commit decision as one
  // latched earlier in the refill.
  assign inval_all = ((state == IDLE) & cpu_flush) |
                     ((state == LAST) & (flush_pend | cpu_flush));
  assign commit    = (state == LAST) & ~(flush_pend | cpu_flush);

  // Outputs are forced quiet while reset is held, even with a request present.
  assign cpu_valid = hit & ~rst;
  assign cpu_stall = cpu_req & ~hit & ~rst;
  assign cpu_rdata = cpu_valid ? line_data : 32'd0;
  assign mem_addr  = (state == REFILL) ? {base_tag, base_idx, issue_cnt} : '0;

  icache_line_store u_store (
    .clk        (clk),
    .rst        (rst),
    .rd_idx     (req.idx),
    .rd_off     (req.off),
    .rd_valid   (line_valid),
    .rd_tag     (line_tag),
    .rd_data    (line_data),
    .wr_en      (refill_we),
    .wr_idx     (base_idx),
    .wr_off     (issue_cnt - off_t'(1)),
    .wr_data    (mem_rdata),
    .commit     (commit),
    .commit_tag (base_tag),
    .inval_all  (inval_all)
  );

  // Refill controller: latch the missing line, stream its words, then commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base_tag   <= '0;
      base_idx   <= '0;
      issue_cnt  <= '0;
      flush_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_start) begin
            base_tag  <= req.tag;
            base_idx  <= req.idx;
            issue_cnt <= '0;
            state     <= REFILL;
          end
        end
        REFILL: begin
          issue_cnt <= issue_cnt + off_t'(1);
          if (cpu_flush) flush_pend <= 1'b1;
          if (last_word) state <= LAST;
        end
        LAST: begin
          flush_pend <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Performance counters: hits per delivering cycle, misses per refill start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (cpu_valid)  hit_count  <= hit_count + 32'd1;
      if (miss_start) miss_count <= miss_count + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped, read-only instruction cache between the core's fetch stage and the word-addressed instruction RAM.
- The RAM has a 12-bit word address and 1-cycle synchronous read latency.
- Serves fetch hits combinationally from register arrays.
- On a miss, stalls fetch and refills one full line by streaming consecutive word reads from the RAM.
- Provides hit/miss counters for performance measurement.

Parameters:
- LINE_WORDS, 4, words per line; power of two, minimum 2.
- SETS, 16, number of lines; power of two.
- MEM_AW, 12, RAM word-address width.
- Derived: OFF_W=log2(LINE_WORDS), IDX_W=log2(SETS), TAG_W=MEM_AW-OFF_W-IDX_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  fetch request valid this cycle
- cpu_addr  in  32  fetch byte address; bits[1:0] ignored; bits above MEM_AW+1 ignored
- cpu_flush  in  1  invalidate all lines (fence.i)
- cpu_rdata  out  32  instruction word; meaningful when cpu_valid=1
- cpu_valid  out  1  hit; cpu_rdata delivered this cycle
- cpu_stall  out  1  request pending, fetch must hold
- mem_addr  out  MEM_AW  word address to instruction RAM read port
- mem_rdata  in  32  RAM output; holds data for the address presented the previous cycle
- hit_count  out  32  hits since reset; wraps
- miss_count  out  32  refills started since reset; wraps

Behaviour:
- Address split on word address w=cpu_addr[MEM_AW+1:2]: offset=w[OFF_W-1:0]; index=w[OFF_W+IDX_W-1:OFF_W]; tag=upper TAG_W bits.
- Storage: valid[SETS], tag[SETS], data[SETS*LINE_WORDS], all registers.
- hit = state==IDLE & cpu_req & valid[index] & tag[index]==tag.
- cpu_valid=hit; cpu_rdata=data[index][offset] when hit, else 0.
- cpu_stall = cpu_req & ~hit. Hit latency is 0 cycles (same cycle).
- State IDLE:
  - On cpu_req & ~hit: latch base={tag,index,0}, clear issue_cnt, miss_count+=1, go to REFILL.
  - If cpu_flush is also high in that cycle, the flush is applied and the refill still starts.
- State REFILL:
  - mem_addr=base+issue_cnt; issue_cnt increments each cycle.
  - From the second REFILL cycle on, capture mem_rdata into data[base.index][issue_cnt-1].
  - After presenting word LINE_WORDS-1, go to LAST.
- State LAST:
  - Capture the final word, write tag and set valid for the line, go to IDLE.
  - If a flush is pending, clear all valids instead; the new line is also invalidated.
- Miss timing for LINE_WORDS=4: miss detected at T; addresses presented T+1..T+4; data captured T+2..T+5; hit at T+6 if cpu_req and cpu_addr are unchanged.
- Outside REFILL, mem_addr=0.
- cpu_addr may change during a stall: the refill completes for the latched line, and the lookup in IDLE uses the current cpu_addr.
- cpu_req dropping mid-refill does not abort the refill.
- Flush:
  - In IDLE, cpu_flush clears all valid bits at the next edge. A request in the same cycle still sees the old valids.
  - In REFILL or LAST, the flush is latched as pending and applied at LAST.
- hit_count increments on every cycle with cpu_valid=1.
- Reset (any time, including mid-refill):
  - state=IDLE, all valid=0, issue_cnt=0, pending flush=0, counters=0, mem_addr=0.
  - Tag and data arrays are not reset.
  - While rst is high, cpu_valid=0, cpu_stall=0, cpu_rdata=0.
- This block never drives the RAM write port; RAM writes bypass the cache, and software flushes after any such write.

Decomposition:
- Package icache_pkg holds:
  - state enum {IDLE, REFILL, LAST};
  - localparams OFF_W, IDX_W, TAG_W;
  - typedefs tag_t and idx_t;
  - function addr_split returning tag/index/offset.
- Sub-module icache_line_store holds valid, tag and data arrays with:
  - combinational read by index;
  - word write port;
  - line-commit (tag and valid) port;
  - flash-invalidate port.
- The FSM, address generation and counters stay in icache_direct_mapped.

Test Plan:
- Cold miss: after reset, RAM word i=32'h1000_0000+i, cpu_req=1, cpu_addr=0x0000_0008 -> cpu_stall=1 for 6 cycles; mem_addr 0,1,2,3 on T+1..T+4; then cpu_valid=1, cpu_rdata=32'h1000_0002; miss_count=1.
- Line hits: then addresses 0x0, 0x4, 0xC on consecutive cycles -> cpu_valid=1 each cycle with data 0x1000_0000, 0x1000_0001, 0x1000_0003; hit_count=4; no mem_addr activity.
- Conflict eviction: fetch 0x0000_0100 (same index 0, tag 1) -> refill of words 64..67. Then re-fetch 0x0 -> miss again; miss_count=3.
- Flush during refill: assert cpu_flush at T+2 of a miss on 0x0000_0010 -> refill completes, line invalid; re-fetch 0x10 -> second refill.
- Reset mid-refill: assert rst at T+3 -> mem_addr=0, cpu_stall=0, counters=0. After release, fetch 0x0 -> full refill starting at mem_addr 0.
- Address change during stall: miss on 0x0, switch cpu_addr to 0x0000_0020 at T+2 -> line 0 still filled; at T+6 a new miss on index 2 starts (mem_addr 8..11).
